// File: rtl/ex_pipeline_slice.sv
// Execute slice of the RV32I pipeline: ID/EX register, forwarding,
// operand select and ALU, EX/MEM register.
module ex_pipeline_slice (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  stall_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  r1_i,
    input  logic [4:0]  r2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  ex_f3_i,
    input  logic        ex_f7_i,
    input  logic        ex_imm_sel_i,
    input  logic        ex_pc_sel_i,
    input  logic        mem_re_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_f3_i,
    input  logic        wb_reg_wr_i,
    input  logic        wb_mem_sel_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_wdata_i,
    input  logic        memwb_wb_reg_wr_i,
    output logic [4:0]  exmem_rd,
    output logic [31:0] exmem_alu,
    output logic [31:0] exmem_wdata,
    output logic        exmem_mem_re,
    output logic        exmem_mem_wr,
    output logic [2:0]  exmem_mem_f3,
    output logic        exmem_wb_reg_wr,
    output logic        exmem_wb_mem_sel
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7;
        logic        imm_sel;
        logic        pc_sel;
        logic        mem_re;
        logic        mem_wr;
        logic [2:0]  mem_f3;
        logic        wb_reg_wr;
        logic        wb_mem_sel;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        mem_re;
        logic        mem_wr;
        logic [2:0]  mem_f3;
        logic        wb_reg_wr;
        logic        wb_mem_sel;
    } ex_mem_t;

    id_ex_t      idex;
    id_ex_t      idex_d;
    ex_mem_t     exmem;
    ex_mem_t     exmem_d;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
    logic [4:0]  shamt;
    logic        sub;
    logic        unused_stall;

    // Stall bits 0 and 3 belong to other stages.
    assign unused_stall = ^{stall_i[3], stall_i[0]};

    always_comb begin
        idex_d            = '0;
        idex_d.pc         = pc_i;
        idex_d.r1         = r1_i;
        idex_d.r2         = r2_i;
        idex_d.rd         = rd_i;
        idex_d.d1         = d1_i;
        idex_d.d2         = d2_i;
        idex_d.imm        = imm_i;
        idex_d.f3         = ex_f3_i;
        idex_d.f7         = ex_f7_i;
        idex_d.imm_sel    = ex_imm_sel_i;
        idex_d.pc_sel     = ex_pc_sel_i;
        idex_d.mem_re     = mem_re_i;
        idex_d.mem_wr     = mem_wr_i;
        idex_d.mem_f3     = mem_f3_i;
        idex_d.wb_reg_wr  = wb_reg_wr_i;
        idex_d.wb_mem_sel = wb_mem_sel_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex <= '0;
        end else if (!stall_i[1]) begin
            idex <= idex_d;
        end
    end

    // The younger result (EX/MEM) wins over MEM/WB; x0 never forwards.
    always_comb begin
        fwd1 = idex.d1;
        if (exmem.wb_reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.r1) begin
            fwd1 = exmem.alu;
        end else if (memwb_wb_reg_wr_i && memwb_rd_i != 5'd0
                     && memwb_rd_i == idex.r1) begin
            fwd1 = memwb_wdata_i;
        end
    end

    always_comb begin
        fwd2 = idex.d2;
        if (exmem.wb_reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.r2) begin
            fwd2 = exmem.alu;
        end else if (memwb_wb_reg_wr_i && memwb_rd_i != 5'd0
                     && memwb_rd_i == idex.r2) begin
            fwd2 = memwb_wdata_i;
        end
    end

    assign a     = idex.pc_sel ? idex.pc : fwd1;
    assign b     = idex.imm_sel ? idex.imm : fwd2;
    assign shamt = b[4:0];
    assign sub   = idex.f7 && !idex.imm_sel;

    always_comb begin
        alu = '0;
        unique case (idex.f3)
            3'b000: alu = sub ? a - b : a + b;
            3'b001: alu = a << shamt;
            3'b010: alu = {31'b0, $signed(a) < $signed(b)};
            3'b011: alu = {31'b0, a < b};
            3'b100: alu = a ^ b;
            3'b101: alu = idex.f7 ? 32'($signed(a) >>> shamt) : a >> shamt;
            3'b110: alu = a | b;
            3'b111: alu = a & b;
        endcase
    end

    always_comb begin
        exmem_d            = '0;
        exmem_d.rd         = idex.rd;
        exmem_d.alu        = alu;
        exmem_d.wdata      = fwd2;
        exmem_d.mem_re     = idex.mem_re;
        exmem_d.mem_wr     = idex.mem_wr;
        exmem_d.mem_f3     = idex.mem_f3;
        exmem_d.wb_reg_wr  = idex.wb_reg_wr;
        exmem_d.wb_mem_sel = idex.wb_mem_sel;
    end

    // A held ID/EX with a free EX/MEM must not issue its instruction twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem <= '0;
        end else if (!stall_i[2]) begin
            exmem <= stall_i[1] ? '0 : exmem_d;
        end
    end

    assign exmem_rd         = exmem.rd;
    assign exmem_alu        = exmem.alu;
    assign exmem_wdata      = exmem.wdata;
    assign exmem_mem_re     = exmem.mem_re;
    assign exmem_mem_wr     = exmem.mem_wr;
    assign exmem_mem_f3     = exmem.mem_f3;
    assign exmem_wb_reg_wr  = exmem.wb_reg_wr;
    assign exmem_wb_mem_sel = exmem.wb_mem_sel;

endmodule

// File: tb/tb_ex_pipeline_slice.sv
// Bench for ex_pipeline_slice: directed cases with literal results,
// then randomized traffic against an instruction-level reference model.
module tb_ex_pipeline_slice;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7;
        logic        imm_sel;
        logic        pc_sel;
        logic        mem_re;
        logic        mem_wr;
        logic [2:0]  mem_f3;
        logic        wb;
        logic        sel;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        re;
        logic        wr;
        logic [2:0]  f3;
        logic        wb;
        logic        sel;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall;
    instr_t      cur;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;

    logic [4:0]  o_rd;
    logic [31:0] o_alu;
    logic [31:0] o_wdata;
    logic        o_re;
    logic        o_wr;
    logic [2:0]  o_f3;
    logic        o_wb;
    logic        o_sel;

    int errors = 0;
    int checks = 0;

    instr_t m_ex;
    res_t   m_mem;

    always #5 clk = ~clk;

    ex_pipeline_slice dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall),
        .pc_i              (cur.pc),
        .r1_i              (cur.r1),
        .r2_i              (cur.r2),
        .rd_i              (cur.rd),
        .d1_i              (cur.d1),
        .d2_i              (cur.d2),
        .imm_i             (cur.imm),
        .ex_f3_i           (cur.f3),
        .ex_f7_i           (cur.f7),
        .ex_imm_sel_i      (cur.imm_sel),
        .ex_pc_sel_i       (cur.pc_sel),
        .mem_re_i          (cur.mem_re),
        .mem_wr_i          (cur.mem_wr),
        .mem_f3_i          (cur.mem_f3),
        .wb_reg_wr_i       (cur.wb),
        .wb_mem_sel_i      (cur.sel),
        .memwb_rd_i        (wb_rd),
        .memwb_wdata_i     (wb_data),
        .memwb_wb_reg_wr_i (wb_we),
        .exmem_rd          (o_rd),
        .exmem_alu         (o_alu),
        .exmem_wdata       (o_wdata),
        .exmem_mem_re      (o_re),
        .exmem_mem_wr      (o_wr),
        .exmem_mem_f3      (o_f3),
        .exmem_wb_reg_wr   (o_wb),
        .exmem_wb_mem_sel  (o_sel)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] src(res_t m, logic [4:0] r,
                                        logic [31:0] d, logic [4:0] wr,
                                        logic [31:0] wd, logic we);
        if (r == 0) return d;
        if (m.wb && m.rd == r) return m.alu;
        if (we && wr == r) return wd;
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(logic [2:0] f3, logic f7,
                                            logic isel, logic [31:0] a,
                                            logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b[4:0];
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (f3)
            3'd0: return (f7 && !isel) ? a + ~b + 32'd1 : a + b;
            3'd1: return a * (32'd1 << sh);
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 1 : 0;
            3'd3: return (a < b) ? 1 : 0;
            3'd4: return a ^ b;
            3'd5: return f7 ? ((a >> sh) | fill) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic res_t exec(instr_t e, res_t m, logic [4:0] wr,
                                  logic [31:0] wd, logic we);
        res_t r;
        logic [31:0] v1, v2;
        v1 = src(m, e.r1, e.d1, wr, wd, we);
        v2 = src(m, e.r2, e.d2, wr, wd, we);
        r.rd    = e.rd;
        r.alu   = alu_ref(e.f3, e.f7, e.imm_sel,
                          e.pc_sel ? e.pc : v1,
                          e.imm_sel ? e.imm : v2);
        r.wdata = v2;
        r.re    = e.mem_re;
        r.wr    = e.mem_wr;
        r.f3    = e.mem_f3;
        r.wb    = e.wb;
        r.sel   = e.sel;
        return r;
    endfunction

    task automatic step();
        res_t nxt;
        nxt = exec(m_ex, m_mem, wb_rd, wb_data, wb_we);
        @(posedge clk);
        if (rst) begin
            m_ex  = '0;
            m_mem = '0;
        end else begin
            if (!stall[2]) m_mem = stall[1] ? '0 : nxt;
            if (!stall[1]) m_ex = cur;
        end
        #1;
        chk("model_alu", o_alu, m_mem.alu);
        chk("model_wdata", o_wdata, m_mem.wdata);
        chk("model_ctl", {20'd0, o_rd, o_re, o_wr, o_f3, o_wb, o_sel},
            {20'd0, m_mem.rd, m_mem.re, m_mem.wr, m_mem.f3, m_mem.wb,
             m_mem.sel});
    endtask

    function automatic instr_t mk(logic [2:0] f3, logic f7, logic isel,
                                  logic [4:0] r1, logic [4:0] r2,
                                  logic [4:0] rd, logic [31:0] d1,
                                  logic [31:0] d2, logic [31:0] imm);
        instr_t i;
        i = '0;
        i.f3 = f3;
        i.f7 = f7;
        i.imm_sel = isel;
        i.r1 = r1;
        i.r2 = r2;
        i.rd = rd;
        i.d1 = d1;
        i.d2 = d2;
        i.imm = imm;
        i.wb = 1'b1;
        return i;
    endfunction

    task automatic run1(instr_t i);
        cur = i;
        step();
        cur = '0;
        step();
    endtask

    instr_t t;

    initial begin
        rst = 1'b1;
        stall = 4'b0;
        wb_rd = 0;
        wb_data = 0;
        wb_we = 0;
        m_ex = '0;
        m_mem = '0;
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5);
        step();
        step();
        chk("rst_alu", o_alu, 32'd0);
        chk("rst_ctl", {27'd0, o_rd}, 32'd0);
        chk("rst_wb", {31'd0, o_wb}, 32'd0);

        rst = 1'b0;
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5);
        step();
        cur = '0;
        step();
        chk("addi_alu", o_alu, 32'd5);
        chk("addi_rd", {27'd0, o_rd}, 32'd1);
        chk("addi_wb", {31'd0, o_wb}, 32'd1);

        run1(mk(3'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 32'd3, 32'd5, 32'd0));
        chk("sub", o_alu, 32'hFFFF_FFFE);
        run1(mk(3'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'h8000_0000, 32'd0, 32'd4));
        chk("sra", o_alu, 32'hF800_0000);
        run1(mk(3'd5, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h8000_0000, 32'd0, 32'd4));
        chk("srl", o_alu, 32'h0800_0000);
        run1(mk(3'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0));
        chk("slt", o_alu, 32'd1);
        run1(mk(3'd3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0));
        chk("sltu", o_alu, 32'd0);

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd7);
        step();
        run1(mk(3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0));
        chk("fwd_exmem", o_alu, 32'd14);

        wb_rd = 5'd1;
        wb_data = 32'd9;
        wb_we = 1'b1;
        run1(mk(3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0));
        chk("fwd_memwb", o_alu, 32'd18);

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd7);
        step();
        run1(mk(3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0));
        chk("fwd_both", o_alu, 32'd14);

        wb_rd = 5'd0;
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h55);
        step();
        run1(mk(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 32'h10, 32'h20, 32'd0));
        chk("x0_nofwd", o_alu, 32'h30);
        wb_we = 1'b0;

        t = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1000);
        t.pc_sel = 1'b1;
        t.pc = 32'h100;
        run1(t);
        chk("auipc", o_alu, 32'h1100);

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'hAB);
        step();
        t = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 32'h200, 32'd0, 32'd8);
        t.wb = 1'b0;
        t.mem_wr = 1'b1;
        t.mem_f3 = 3'd2;
        run1(t);
        chk("store_wdata", o_wdata, 32'hAB);
        chk("store_addr", o_alu, 32'h208);
        chk("store_wr", {31'd0, o_wr}, 32'd1);

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h11);
        step();
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h22);
        step();
        stall = 4'b0110;
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h33);
        step();
        chk("hold_exmem", o_alu, 32'h11);
        stall = 4'b0;
        cur = '0;
        step();
        chk("hold_idex", o_alu, 32'h22);
        step();

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h11);
        step();
        stall = 4'b0010;
        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h22);
        step();
        chk("bubble_wb", {31'd0, o_wb}, 32'd0);
        chk("bubble_alu", o_alu, 32'd0);
        stall = 4'b0;
        cur = '0;
        step();
        chk("bubble_release", o_alu, 32'h11);

        cur = mk(3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h11);
        step();
        step();
        rst = 1'b1;
        stall = 4'b0110;
        step();
        chk("rst_stall_alu", o_alu, 32'd0);
        chk("rst_stall_wb", {31'd0, o_wb}, 32'd0);
        rst = 1'b0;
        stall = 4'b0;
        cur = '0;
        step();
        chk("rst_stall_idex", {27'd0, o_rd}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            t = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            t.r1 = 5'($urandom_range(0, 3));
            t.r2 = 5'($urandom_range(0, 3));
            t.rd = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) t.d1 = 32'h8000_0000;
            cur = t;
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            wb_we = 1'($urandom);
            stall = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_pipeline_slice.md
Name: ex_pipeline_slice

Overview:
- Execute slice of the 5-stage RV32I pipeline: ID/EX pipeline register, combinational execute stage (operand select, forwarding, ALU), EX/MEM pipeline register.
- Inputs come from the decode stage (decoded fields, register-file read data, immediate, control bits) and from the MEM/WB register (write-back forwarding).
- Outputs are the EX/MEM register contents, which drive data memory and the MEM/WB register.

Parameters:
- None. Widths are fixed: data 32, register address 5, stall bus 4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall_i  in  4  per-stage hold; bit1 = hold ID/EX, bit2 = hold EX/MEM; bits 0 and 3 ignored
- pc_i  in  32  PC of the decoded instruction
- r1_i, r2_i  in  5 each  source register addresses
- rd_i  in  5  destination register
- d1_i, d2_i  in  32 each  register-file read data
- imm_i  in  32  sign-extended immediate
- ex_f3_i  in  3  ALU funct3
- ex_f7_i  in  1  funct7 bit 5 (instr[30]): SUB/SRA select
- ex_imm_sel_i  in  1  1 = operand B is imm
- ex_pc_sel_i  in  1  1 = operand A is PC
- mem_re_i, mem_wr_i  in  1 each  load / store enables
- mem_f3_i  in  3  load/store size and sign
- wb_reg_wr_i  in  1  register write-back enable
- wb_mem_sel_i  in  1  1 = write back memory data
- memwb_rd_i  in  5  MEM/WB destination
- memwb_wdata_i  in  32  MEM/WB write-back value
- memwb_wb_reg_wr_i  in  1  MEM/WB write enable
- exmem_rd  out  5
- exmem_alu  out  32  ALU result / memory address
- exmem_wdata  out  32  store data
- exmem_mem_re, exmem_mem_wr  out  1 each
- exmem_mem_f3  out  3
- exmem_wb_reg_wr  out  1
- exmem_wb_mem_sel  out  1

Behaviour:
- ID/EX register
  - Captures every *_i field (pc, r1, r2, rd, d1, d2, imm, f3, f7, imm_sel, pc_sel, mem_re, mem_wr, mem_f3, wb_reg_wr, wb_mem_sel) on each rising edge.
  - On rst: all fields cleared to 0, which acts as a NOP.
  - When stall_i[1] = 1: holds its value.
- Forwarding, operand 1 (fwd1), priority order:
  1. If EX/MEM wb_reg_wr = 1, exmem_rd != 0 and exmem_rd == idex.r1: use exmem_alu.
  2. Else if memwb_wb_reg_wr_i = 1, memwb_rd_i != 0 and memwb_rd_i == idex.r1: use memwb_wdata_i.
  3. Else use idex.d1.
- Forwarding, operand 2 (fwd2): same rules, using r2 and d2.
- Destination x0 never forwards.
- Operand select: A = pc_sel ? idex.pc : fwd1; B = imm_sel ? idex.imm : fwd2.
- ALU, combinational, selected by f3:
  - 000: ADD; SUB only when f7 = 1 and imm_sel = 0 (ADDI never subtracts).
  - 001: SLL by B[4:0].
  - 010: SLT, signed, result 0 or 1.
  - 011: SLTU, unsigned, result 0 or 1.
  - 100: XOR.
  - 101: SRL; SRA when f7 = 1, for both register and immediate forms.
  - 110: OR.
  - 111: AND.
  - Arithmetic is modulo 2^32 (wraps); no overflow flag.
- Store data: wdata = fwd2, always the forwarded register value, never imm.
- The decoder encodes LUI/AUIPC/loads/stores/JAL link as ADD with suitable pc_sel/imm; this slice has no branch logic.
- EX/MEM register
  - Captures rd, alu, wdata and the mem/wb control fields from ID/EX on each rising edge.
  - On rst: all fields cleared to 0.
  - When stall_i[2] = 1: holds.
  - When stall_i[1] = 1 and stall_i[2] = 0: loads a bubble (mem_re = mem_wr = wb_reg_wr = 0, other fields 0).
- Reset is synchronous and takes priority over stall.
- Latency: inputs present at edge N appear on exmem_* after edge N+1.
- Back-to-back dependent instructions forward with no stall. Load-use hazards are the caller's responsibility.

Test Plan:
- Reset, then ADDI r1 = 0 + 5: exmem_alu = 5, exmem_rd = 1, exmem_wb_reg_wr = 1 two edges after input; during rst all outputs = 0.
- SUB with d1 = 3, d2 = 5: exmem_alu = 0xFFFFFFFE. SRA of 0x80000000 by 4: 0xF8000000. SRL of the same: 0x08000000. SLT(-1, 1) = 1; SLTU(-1, 1) = 0.
- Forwarding:
  - Back-to-back ADDI x1 = 7 then ADD x2 = x1 + x1 with stale d1 = 0: exmem_alu = 14.
  - With the EX/MEM match removed and memwb_rd_i = 1, memwb_wdata_i = 9: result 18.
  - Both paths match: EX/MEM wins.
- rd = 0 in EX/MEM with wb_reg_wr = 1 and r1 = 0: no forwarding; d1 is used.
- AUIPC-style (pc_sel = 1, imm_sel = 1, pc = 0x100, imm = 0x1000): exmem_alu = 0x1100. Store with r2 forwarded value 0xAB: exmem_wdata = 0xAB, exmem_mem_wr = 1.
- Stall:
  - stall_i = 0b0110: both registers hold for the cycle.
  - stall_i = 0b0010: ID/EX holds and EX/MEM shows the bubble (wb_reg_wr = 0, mem_wr = 0).
  - rst asserted during a stall: all registers clear.
